config_loader: RTL
==================

// Module: config_loader
// PURPOSE
//   Configuration-bus initiator for the tile array. Accepts a stream of 32-bit
//   (address, data) word pairs over a valid/ready handshake and drives the shared
//   config_addr/config_data bus that every tile decodes ({feature_id, tile_id}).
//   Sits at the array top, between the host/bitstream source and all tiles.
// PARAMETERS
//   HOLD_CYCLES  1             cycles a write is held on the bus (>=1)
//   IDLE_ADDR    32'h0000_0000 bus address when idle; feature 0 is never decoded
//   END_ADDR     32'hFFFF_FFFF address word that terminates the stream
// PORTS
//   clk          in   1   clock
//   reset        in   1   asynchronous, active-low reset
//   start        in   1   begin loading; sampled only in IDLE
//   in_data      in   32  stream word: address, then data, alternating
//   in_valid     in   1   in_data valid
//   in_ready     out  1   loader accepts in_data this cycle
//   config_addr  out  32  bus address {feature_id[31:16], tile_id[15:0]}
//   config_data  out  32  bus write data
//   config_valid out  1   high while a write is on the bus
//   busy         out  1   high from start accept until stream end
//   done         out  1   stream terminated; held until next start
//   err          out  1   sticky: an address word equal to IDLE_ADDR was seen
//   write_count  out  16  writes issued this load, saturates at 16'hFFFF
// BEHAVIOUR
//   - reset low (async): state=IDLE, config_addr=IDLE_ADDR, config_data=0,
//     config_valid=0, busy=0, done=0, err=0, write_count=0, hold counter=0.
//   - All outputs registered except in_ready (decoded from registered state).
//   - Transfer = in_valid & in_ready on a rising clk edge.
//   - FSM: IDLE, ADDR, DATA, ISSUE.
//     IDLE : in_ready=0. start=1 -> ADDR; clears done, err, write_count; busy=1.
//     ADDR : in_ready=1. On transfer: word==END_ADDR -> IDLE, busy=0, done=1;
//            word==IDLE_ADDR -> err=1, skip flag set, -> DATA;
//            else latch address, -> DATA. (END_ADDR check takes priority.)
//     DATA : in_ready=1. On transfer: skip set -> clear skip, -> ADDR (no write);
//            else latch data, -> ISSUE.
//     ISSUE: in_ready=0. config_addr/config_data = latched pair, config_valid=1,
//            for exactly HOLD_CYCLES cycles; on the last cycle write_count+=1
//            (saturating), then bus returns to IDLE_ADDR/0, valid=0, -> ADDR.
//   - Timing: data word transferred at edge N -> bus shows write in cycles
//     N+1..N+HOLD_CYCLES; IDLE_ADDR restored and in_ready=1 from N+HOLD_CYCLES+1.
//     Peak throughput one write per HOLD_CYCLES+2 cycles.
//   - config_addr never carries a non-idle value while config_valid=0.
//   - start while busy is ignored; in_valid while in IDLE/ISSUE is not consumed.
//   - in_data/in_valid may stall arbitrarily; FSM waits, bus stays idle.
//   - Reset mid-ISSUE: bus returns to IDLE_ADDR immediately; partial pair is
//     dropped; a new start is required after reset release.
//   - Stream ending after an address word (no data) is not detected: loader
//     waits in DATA until a word arrives or reset.
// TESTING
//   1. start; stream 0x0007_0003, 0x1234_5678, 0xFFFF_FFFF -> one cycle with
//      config_addr=0x0007_0003, config_data=0x1234_5678, valid=1; then
//      addr=0; done=1, busy=0, write_count=1, err=0.
//   2. Same three words with in_valid toggled 1-0-0-1-0-1 -> identical bus
//      trace and counts; no word consumed while in_ready=0.
//   3. HOLD_CYCLES=3, pairs (0x0004_0001,0x2),(0x0006_0001,0x5), END ->
//      valid high exactly 3 cycles per pair, 2-cycle gap min, write_count=2.
//   4. Address word 0x0000_0000 with data 0xDEAD_BEEF, then END -> err=1,
//      config_valid never asserted, write_count=0, done=1.
//   5. reset low during ISSUE -> same cycle config_valid=0, config_addr=0;
//      after release, in_ready=0 until start; next start clears err/count.
//   6. start pulsed while busy (in ADDR) -> no effect; done clears only on a
//      start after the END word.

Source files
------------

// File: rtl/config_loader.sv
// Configuration-bus initiator: consumes (address, data) word pairs over valid/ready
// and issues each pair as a held write on the shared config_addr/config_data bus.
module config_loader #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] END_ADDR    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] write_count
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [31:0]   addr_q, addr_n;
  logic          skip, skip_n;
  logic [HW-1:0] hold, hold_n;
  logic [31:0]   config_addr_n, config_data_n;
  logic          config_valid_n, busy_n, done_n, err_n;
  logic [15:0]   write_count_n;
  logic          xfer;

  always_comb begin
    state_n        = state;
    addr_n         = addr_q;
    skip_n         = skip;
    hold_n         = hold;
    config_addr_n  = config_addr;
    config_data_n  = config_data;
    config_valid_n = config_valid;
    busy_n         = busy;
    done_n         = done;
    err_n          = err;
    write_count_n  = write_count;
    in_ready       = (state == ADDR) || (state == DATA);
    xfer           = in_valid && in_ready;

    case (state)
      IDLE: begin
        if (start) begin
          state_n       = ADDR;
          busy_n        = 1'b1;
          done_n        = 1'b0;
          err_n         = 1'b0;
          write_count_n = '0;
          skip_n        = 1'b0;
        end
      end
      ADDR: begin
        // END_ADDR is tested first so a stream terminator is never flagged as an error
        if (xfer) begin
          if (in_data == END_ADDR) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (in_data == IDLE_ADDR) begin
            err_n   = 1'b1;
            skip_n  = 1'b1;
            state_n = DATA;
          end else begin
            addr_n  = in_data;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (skip) begin
            skip_n  = 1'b0;
            state_n = ADDR;
          end else begin
            config_addr_n  = addr_q;
            config_data_n  = in_data;
            config_valid_n = 1'b1;
            hold_n         = '0;
            state_n        = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (hold == HOLD_LAST) begin
          config_addr_n  = IDLE_ADDR;
          config_data_n  = '0;
          config_valid_n = 1'b0;
          if (write_count != '1) write_count_n = write_count + 16'd1;
          state_n = ADDR;
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      skip         <= 1'b0;
      hold         <= '0;
      config_addr  <= IDLE_ADDR;
      config_data  <= '0;
      config_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      write_count  <= '0;
    end else begin
      state        <= state_n;
      addr_q       <= addr_n;
      skip         <= skip_n;
      hold         <= hold_n;
      config_addr  <= config_addr_n;
      config_data  <= config_data_n;
      config_valid <= config_valid_n;
      busy         <= busy_n;
      done         <= done_n;
      err          <= err_n;
      write_count  <= write_count_n;
    end
  end

endmodule
